// File: rtl/serial_word_cmpr.sv
// Multi-lane, word-framed serial magnitude comparator (MSB- or LSB-first bit order).
// Define SERIAL_CMPR_SIGNED_EN for a two's-complement signed comparison.
module serial_word_cmpr #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CH    = 4
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_start,
    input  logic          i_msb_first,
    input  logic          i_bit_valid,
    input  logic [CH-1:0] i_a,
    input  logic [CH-1:0] i_b,
    output logic          o_busy,
    output logic          o_done,
    output logic [CH-1:0] o_alessb,
    output logic [CH-1:0] o_aequalb,
    output logic [CH-1:0] o_agreatb
);

    localparam int unsigned     CntW    = $clog2(WIDTH + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    localparam logic [1:0] LaneEq = 2'b00;
    localparam logic [1:0] LaneLt = 2'b01;
    localparam logic [1:0] LaneGt = 2'b10;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e               r_state, w_state_nxt;
    logic [CntW-1:0]      r_cnt, w_cnt_nxt;
    logic                 r_mode, w_mode_nxt;
    logic [CH-1:0][1:0]   r_lane, w_lane_nxt, w_lane_upd;
    logic [CH-1:0]        r_lt, w_lt_nxt;
    logic [CH-1:0]        r_eq, w_eq_nxt;
    logic [CH-1:0]        r_gt, w_gt_nxt;

    logic                 w_last;
    logic                 w_sign;
    logic [CH-1:0]        w_diff;
    logic [CH-1:0]        w_agt;

    assign w_last = (r_cnt == LastCnt);
    assign w_diff = i_a ^ i_b;
    assign w_agt  = i_a & ~i_b;

`ifdef SERIAL_CMPR_SIGNED_EN
    // Sign bit arrives first in MSB-first order and last in LSB-first order.
    assign w_sign = r_mode ? (r_cnt == '0) : w_last;
`else
    assign w_sign = 1'b0;
`endif

    // MSB-first freezes a lane on its first difference; LSB-first lets later bits overwrite.
    always_comb begin
        w_lane_upd = r_lane;
        for (int l = 0; l < int'(CH); l++) begin
            if (w_diff[l] && (!r_mode || r_lane[l] == LaneEq)) begin
                w_lane_upd[l] = (w_agt[l] ^ w_sign) ? LaneGt : LaneLt;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_mode_nxt  = r_mode;
        w_lane_nxt  = r_lane;
        w_lt_nxt    = r_lt;
        w_eq_nxt    = r_eq;
        w_gt_nxt    = r_gt;
        unique case (r_state)
            StIdle: begin
                if (i_start) begin
                    w_state_nxt = StRun;
                    w_cnt_nxt   = '0;
                    w_mode_nxt  = i_msb_first;
                    w_lane_nxt  = '0;
                end
            end
            StRun: begin
                if (i_bit_valid) begin
                    w_cnt_nxt  = r_cnt + CntW'(1);
                    w_lane_nxt = w_lane_upd;
                    if (w_last) begin
                        w_state_nxt = StDone;
                        for (int l = 0; l < int'(CH); l++) begin
                            w_lt_nxt[l] = (w_lane_upd[l] == LaneLt);
                            w_eq_nxt[l] = (w_lane_upd[l] == LaneEq);
                            w_gt_nxt[l] = (w_lane_upd[l] == LaneGt);
                        end
                    end
                end
            end
            StDone: begin
                w_state_nxt = StIdle;
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_mode  <= 1'b0;
            r_lane  <= '0;
            r_lt    <= '0;
            r_eq    <= '1;
            r_gt    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_mode  <= w_mode_nxt;
            r_lane  <= w_lane_nxt;
            r_lt    <= w_lt_nxt;
            r_eq    <= w_eq_nxt;
            r_gt    <= w_gt_nxt;
        end
    end

    assign o_busy    = (r_state == StRun);
    assign o_done    = (r_state == StDone);
    assign o_alessb  = r_lt;
    assign o_aequalb = r_eq;
    assign o_agreatb = r_gt;

endmodule
